// File: rtl/alu_exec_if.sv
// Handshake and operand bus between the ID/EX register, the execute ALU and the EX/MEM register.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Operation;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare/branch ops, iterative 1-bit/cycle shifter,
// and an optional 32-cycle shift-add multiplier compiled in when ALU_MUL_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    alu_exec_if.slave  bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_BLT = 4'b1010;
    localparam logic [3:0] OP_BGE = 4'b1011;
    localparam logic [3:0] OP_SLT = 4'b1100;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1101;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       op_q, op_d;
    logic [4:0]       sh_cnt_q, sh_cnt_d;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [5:0]       mul_cnt_q, mul_cnt_d;
`endif

    logic in_ready;
    logic accept;

    // Everything that finishes in one cycle; illegal codes fall through to zero.
    function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_AND:  single_op = a & b;
            OP_OR:   single_op = a | b;
            OP_ADD:  single_op = a + b;
            OP_XOR:  single_op = a ^ b;
            OP_SUB:  single_op = a - b;
            OP_BEQ:  single_op = {{(WIDTH-1){1'b0}}, a == b};
            OP_BNE:  single_op = {{(WIDTH-1){1'b0}}, a != b};
            OP_BLT:  single_op = {{(WIDTH-1){1'b0}}, sa < sb};
            OP_BGE:  single_op = {{(WIDTH-1){1'b0}}, sa >= sb};
            OP_SLT:  single_op = {{(WIDTH-1){1'b0}}, sa < sb};
            default: single_op = '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] v);
        case (op)
            OP_SLL:  shift_step = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  shift_step = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift_step = v;
        endcase
    endfunction

    // Combinational out_ready -> in_ready path lets DONE hand off to the next op without a bubble.
    assign in_ready = !reset && !flush &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = res_q;
    assign bus.Zero      = zero_q;

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        zero_d   = zero_q;
        op_d     = op_q;
        sh_cnt_d = sh_cnt_q;
`ifdef ALU_MUL_EN
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        mul_cnt_d = mul_cnt_q;
`endif

        case (state_q)
            S_SHIFT: begin
                res_d    = shift_step(op_q, res_q);
                sh_cnt_d = sh_cnt_q - 5'd1;
                if (sh_cnt_q == 5'd1) state_d = S_DONE;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d   = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d  = {1'b0, mplier_q[WIDTH-1:1]};
                mul_cnt_d = mul_cnt_q - 6'd1;
                if (mul_cnt_q == 6'd1) begin
                    state_d = S_DONE;
                    res_d   = acc_d;
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // accept is only possible from IDLE or a consumed DONE, so it overrides the case above.
        if (accept) begin
            op_d = bus.Operation;
            case (bus.Operation)
                OP_SLL, OP_SRL, OP_SRA: begin
                    res_d    = bus.SrcA;
                    sh_cnt_d = bus.SrcB[4:0];
                    state_d  = (bus.SrcB[4:0] == 5'd0) ? S_DONE : S_SHIFT;
                end
`ifdef ALU_MUL_EN
                OP_MUL: begin
                    acc_d     = '0;
                    mcand_d   = bus.SrcA;
                    mplier_d  = bus.SrcB;
                    mul_cnt_d = 6'd32;
                    state_d   = S_MUL;
                end
`endif
                default: begin
                    res_d   = single_op(bus.Operation, bus.SrcA, bus.SrcB);
                    state_d = S_DONE;
                end
            endcase
        end

        if (state_d == S_DONE) zero_d = (res_d == '0);

        if (flush) begin
            state_d  = S_IDLE;
            res_d    = '0;
            zero_d   = 1'b0;
            sh_cnt_d = 5'd0;
`ifdef ALU_MUL_EN
            acc_d     = '0;
            mul_cnt_d = 6'd0;
`endif
        end

        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            res_q       <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            op_q        <= 4'd0;
            sh_cnt_q    <= 5'd0;
`ifdef ALU_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            mul_cnt_q <= 6'd0;
`endif
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            sh_cnt_q    <= sh_cnt_d;
`ifdef ALU_MUL_EN
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            mul_cnt_q <= mul_cnt_d;
`endif
        end
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `Operation` code from the ALU controller, together with the two register/immediate operands, and produces the 32-bit result and branch outcome. It sits between the ID/EX pipeline register and the EX/MEM register. Logic, add/sub, compare and branch ops complete in one cycle; shifts run on an iterative 1-bit/cycle shifter; optional MUL runs on a 32-cycle shift-add engine. A valid/ready handshake on both sides lets the hazard unit stall the pipeline while the unit is busy.

## Interface
- `WIDTH`, 32, datapath width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous pipeline flush; aborts any op in flight.
- `in_valid` in 1: operands and `Operation` are valid.
- `in_ready` out 1: unit accepts an op this cycle.
- `Operation` in 4: op code (encoding below).
- `SrcA` in 32: operand A.
- `SrcB` in 32: operand B.
- `out_valid` out 1: `ALUResult`/`Zero` are valid.
- `out_ready` in 1: downstream consumes the result.
- `ALUResult` out 32: result; branches return `{31'b0, taken}`.
- `Zero` out 1: `ALUResult == 0`, registered together with `ALUResult`.

## Operation
- Encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR.
  - 0100 SLL; 0101 SRL; 0110 SUB; 0111 SRA.
  - 1000 BEQ; 1001 BNE; 1010 BLT (signed); 1011 BGE (signed).
  - 1100 SLT (signed, result 0/1); 1101 MUL (macro); 1110/1111 illegal.
- ADD/SUB/MUL wrap mod 2^32. Shift amount is `SrcB[4:0]`; `SrcB[31:5]` is ignored.
- Illegal codes produce `ALUResult=0` and `Zero=1` with single-cycle latency.
- Handshake:
  - An op is accepted on a rising edge where `in_valid && in_ready`.
  - Operands are captured on accept; input changes after accept have no effect.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE: on accept, a single-cycle op goes to DONE with the result registered.
  - IDLE: on accept, a shift with amount 0 goes to DONE with result = `SrcA`.
  - IDLE: on accept, a shift with amount >0 loads a 5-bit down-counter and goes to SHIFT.
  - IDLE: on accept, MUL goes to MUL with a 6-bit counter of 32.
  - SHIFT: one 1-bit shift per cycle (SRA replicates bit 31); goes to DONE when the counter reaches 0.
  - MUL: each cycle, adds the multiplicand to the accumulator if the multiplier LSB is 1, then shifts the multiplicand left and the multiplier right. Fixed 32 iterations, no early exit; goes to DONE after the last one.
  - DONE: `out_valid=1`; holds `ALUResult`/`Zero` stable until `out_ready`.
  - DONE: on `out_ready`, returns to IDLE, or to the next op's state if a new op is accepted in the same cycle.
- `in_ready = !reset && (state==IDLE || (state==DONE && out_ready))`. This is a combinational path from `out_ready` to `in_ready`.
- Flush:
  - Any state goes to IDLE on the next edge; `out_valid` goes to 0 and the result is discarded.
  - `in_ready` is forced to 0 while `flush` is high, so an op is never accepted in a flush cycle.
- Reset mid-op: same as flush. The counters and accumulator are cleared.

## Timing
- Reset values: `out_valid=0`, `ALUResult=0`, `Zero=0`, state IDLE. `in_ready=0` while `reset` is high and 1 in the first cycle after it.
- Latency from the accept edge k to the first cycle with `out_valid=1`:
  - Single-cycle ops and shift-by-0: k+1.
  - Shift by n: k+1+n.
  - MUL: k+33.
- Throughput:
  - One single-cycle op per clock when `out_ready` is held high.
  - Shift by n: one result per n+1 cycles. MUL: one result per 33 cycles.
- Back-pressure: with `out_ready=0`, DONE holds indefinitely and `in_ready=0`.

## Configuration
- `ALU_MUL_EN` defined: the MUL state, 32-bit accumulator, multiplicand/multiplier registers and 6-bit counter are compiled in. Code 1101 computes the low 32 bits of `SrcA*SrcB` (identical for signed and unsigned).
- `ALU_MUL_EN` undefined: no MUL hardware. Code 1101 is treated as illegal (result 0, k+1 latency).

## Test plan
- After reset, ADD `SrcA=0xFFFFFFFF`, `SrcB=1`, `out_ready=1` -> `out_valid` at k+1, `ALUResult=0`, `Zero=1`; a SUB 5-7 accepted back-to-back at k+1 -> `0xFFFFFFFE` at k+2.
- SRA `SrcA=0x80000000`, `SrcB=0x23` (amount 3) -> `in_ready=0` during k+1..k+3, `ALUResult=0xF0000000` at k+4; SLL by 0 -> `SrcA` at k+1.
- Branches: BLT -1,1 -> 1; BGE -1,1 -> 0; BEQ 7,7 -> 1 with `Zero=0`; BNE 7,7 -> 0 with `Zero=1`; SLT 0x80000000,0 -> 1.
- Back-pressure: SRL 0xF0,4 with `out_ready=0` for 10 cycles -> `ALUResult=0x0F` held stable, `in_ready=0`; `out_ready=1` accepts the next op the same cycle.
- Flush and reset: `flush` asserted 2 cycles into an SLL by 20 -> `out_valid` never rises, IDLE next cycle; `flush` with `in_valid` -> no accept. `reset` mid-shift -> outputs 0.
- `ALU_MUL_EN`: MUL 0xFFFFFFFF*0xFFFFFFFF -> 1 at k+33; 12345*6789 -> 83810205. Without the macro, 1101 -> 0 at k+1.
